// File: rtl/fft_stage_ctrl_pkg.sv
// Shared definitions for the radix-2 FFT sequencer.
// Default geometry and the controller state encoding.
package fft_pkg;

    localparam int N_LOG2_DEF     = 10;
    localparam int RD_LAT_DEF     = 1;
    localparam int BF_LATENCY_DEF = 3;

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DRAIN,
        DONE
    } state_t;

endpackage

// File: rtl/fft_stage_ctrl_if.sv
// Control bundle between the FFT sequencer and the datapath.
// The master side is the sequencer; the slave side is its user.
interface fft_stage_ctrl_if
    import fft_pkg::*;
#(
    parameter int N_LOG2  = N_LOG2_DEF,
    parameter int STAGE_W = $clog2(N_LOG2)
);
    logic                i_start;
    logic                o_busy;
    logic                o_done;
    logic [STAGE_W-1:0]  o_stage;
    logic                o_rd_en;
    logic [N_LOG2-1:0]   o_rd_addr_a;
    logic [N_LOG2-1:0]   o_rd_addr_b;
    logic [N_LOG2-2:0]   o_tw_addr;
    logic                o_bf_start;
    logic                o_wr_en;
    logic [N_LOG2-1:0]   o_wr_addr_a;
    logic [N_LOG2-1:0]   o_wr_addr_b;

    modport master (
        input  i_start,
        output o_busy, o_done, o_stage,
        output o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr,
        output o_bf_start, o_wr_en, o_wr_addr_a, o_wr_addr_b
    );

    modport slave (
        output i_start,
        input  o_busy, o_done, o_stage,
        input  o_rd_en, o_rd_addr_a, o_rd_addr_b, o_tw_addr,
        input  o_bf_start, o_wr_en, o_wr_addr_a, o_wr_addr_b
    );

endinterface

// File: rtl/fft_stage_ctrl_addr_gen.sv
// Butterfly address generator: (stage, index) -> RAM pair and twiddle.
// Purely combinational so an IFFT sequencer can share it.
module fft_addr_gen
    import fft_pkg::*;
#(
    parameter int N_LOG2  = N_LOG2_DEF,
    parameter int STAGE_W = $clog2(N_LOG2)
) (
    input  logic [STAGE_W-1:0] i_s,
    input  logic [N_LOG2-2:0]  i_k,
    output logic [N_LOG2-1:0]  o_addr_a,
    output logic [N_LOG2-1:0]  o_addr_b,
    output logic [N_LOG2-2:0]  o_tw_addr
);
    localparam logic [N_LOG2-1:0]  ONE    = N_LOG2'(1);
    localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(N_LOG2 - 1);

    logic [N_LOG2-1:0] w_k;
    logic [N_LOG2-1:0] w_half;
    logic [N_LOG2-1:0] w_pos;
    logic [N_LOG2-1:0] w_grp;
    logic [N_LOG2-1:0] w_a;

    // split k into group and in-group position, then spread the groups
    always_comb begin
        w_k       = {1'b0, i_k};
        w_half    = ONE << i_s;
        w_pos     = w_k & (w_half - ONE);
        w_grp     = w_k >> i_s;
        w_a       = ((w_grp << i_s) << 1) | w_pos;
        o_addr_a  = w_a;
        o_addr_b  = w_a | w_half;
        o_tw_addr = w_pos[N_LOG2-2:0] << (S_LAST - i_s);
    end

endmodule

// File: rtl/fft_stage_ctrl.sv
// In-place radix-2 DIT FFT sequencer: one butterfly per clock,
// with a pipeline drain between stages so reads never pass writes.
module fft_stage_ctrl
    import fft_pkg::*;
#(
    parameter int N_LOG2     = N_LOG2_DEF,
    parameter int RD_LAT     = RD_LAT_DEF,
    parameter int BF_LATENCY = BF_LATENCY_DEF,
    parameter int STAGE_W    = $clog2(N_LOG2)
) (
    input  logic              clk,
    input  logic              reset,
    fft_stage_ctrl_if.master  bus
);
    localparam int D   = RD_LAT + BF_LATENCY;
    localparam int K_W = N_LOG2 - 1;
    localparam int D_W = $clog2(D + 1);

    localparam logic [K_W-1:0]     K_LAST = '1;
    localparam logic [STAGE_W-1:0] S_LAST = STAGE_W'(N_LOG2 - 1);
    localparam logic [D_W-1:0]     D_LAST = D_W'(D - 1);

    state_t              r_state, w_state_nx;
    logic [K_W-1:0]      r_k, w_k_nx;
    logic [STAGE_W-1:0]  r_stage, w_stage_nx;
    logic [D_W-1:0]      r_dcnt, w_dcnt_nx;
    logic                w_rd_en_nx;

    logic [N_LOG2-1:0]   w_addr_a, w_addr_b;
    logic [N_LOG2-2:0]   w_tw_addr;

    logic                r_rd_en;
    logic [N_LOG2-1:0]   r_rd_addr_a, r_rd_addr_b;
    logic [N_LOG2-2:0]   r_tw_addr;

    logic                r_en_sr [D];
    logic [N_LOG2-1:0]   r_wa_sr [D];
    logic [N_LOG2-1:0]   r_wb_sr [D];

    // addresses are formed from next-cycle (stage, k) so they register
    fft_addr_gen #(
        .N_LOG2  (N_LOG2),
        .STAGE_W (STAGE_W)
    ) u_addr_gen (
        .i_s       (w_stage_nx),
        .i_k       (w_k_nx),
        .o_addr_a  (w_addr_a),
        .o_addr_b  (w_addr_b),
        .o_tw_addr (w_tw_addr)
    );

    // sequencer state, butterfly counter, stage and drain counter
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
            r_k     <= '0;
            r_stage <= '0;
            r_dcnt  <= '0;
        end else begin
            r_state <= w_state_nx;
            r_k     <= w_k_nx;
            r_stage <= w_stage_nx;
            r_dcnt  <= w_dcnt_nx;
        end
    end

    // next-state logic; drain lasts exactly the read+butterfly latency
    always_comb begin
        w_state_nx = r_state;
        w_k_nx     = r_k;
        w_stage_nx = r_stage;
        w_dcnt_nx  = r_dcnt;
        w_rd_en_nx = 1'b0;
        unique case (r_state)
            IDLE: begin
                if (bus.i_start) begin
                    w_state_nx = RUN;
                    w_k_nx     = '0;
                    w_stage_nx = '0;
                    w_rd_en_nx = 1'b1;
                end
            end
            RUN: begin
                if (r_k == K_LAST) begin
                    w_state_nx = DRAIN;
                    w_dcnt_nx  = '0;
                end else begin
                    w_k_nx     = r_k + K_W'(1);
                    w_rd_en_nx = 1'b1;
                end
            end
            DRAIN: begin
                if (r_dcnt == D_LAST) begin
                    if (r_stage == S_LAST) begin
                        w_state_nx = DONE;
                    end else begin
                        w_state_nx = RUN;
                        w_stage_nx = r_stage + STAGE_W'(1);
                        w_k_nx     = '0;
                        w_rd_en_nx = 1'b1;
                    end
                end else begin
                    w_dcnt_nx = r_dcnt + D_W'(1);
                end
            end
            DONE: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // registered read port; addresses are zeroed while idle
    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_en     <= 1'b0;
            r_rd_addr_a <= '0;
            r_rd_addr_b <= '0;
            r_tw_addr   <= '0;
        end else begin
            r_rd_en     <= w_rd_en_nx;
            r_rd_addr_a <= w_rd_en_nx ? w_addr_a : '0;
            r_rd_addr_b <= w_rd_en_nx ? w_addr_b : '0;
            r_tw_addr   <= w_rd_en_nx ? w_tw_addr : '0;
        end
    end

    // strobe/address delay line feeding butterfly start and write-back
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < D; i++) begin
                r_en_sr[i] <= 1'b0;
                r_wa_sr[i] <= '0;
                r_wb_sr[i] <= '0;
            end
        end else begin
            r_en_sr[0] <= r_rd_en;
            r_wa_sr[0] <= r_rd_addr_a;
            r_wb_sr[0] <= r_rd_addr_b;
            for (int i = 1; i < D; i++) begin
                r_en_sr[i] <= r_en_sr[i-1];
                r_wa_sr[i] <= r_wa_sr[i-1];
                r_wb_sr[i] <= r_wb_sr[i-1];
            end
        end
    end

    assign bus.o_busy      = (r_state != IDLE);
    assign bus.o_done      = (r_state == DONE);
    assign bus.o_stage     = r_stage;
    assign bus.o_rd_en     = r_rd_en;
    assign bus.o_rd_addr_a = r_rd_addr_a;
    assign bus.o_rd_addr_b = r_rd_addr_b;
    assign bus.o_tw_addr   = r_tw_addr;
    assign bus.o_bf_start  = r_en_sr[RD_LAT-1];
    assign bus.o_wr_en     = r_en_sr[D-1];
    assign bus.o_wr_addr_a = r_wa_sr[D-1];
    assign bus.o_wr_addr_b = r_wb_sr[D-1];

endmodule

// File: tb/tb_fft_stage_ctrl.sv
// Self-checking bench for fft_stage_ctrl: scoreboarded 8-point run,
// start/reset corner cases and a 1024-point sweep.
module tb_fft_stage_ctrl;

    logic clk;
    logic reset;
    int   n_cmp;
    int   n_bad;

    typedef struct {
        int a;
        int b;
        int tw;
        int s;
    } rd_t;

    typedef struct {
        int a;
        int b;
        int due;
    } wr_t;

    rd_t rd_q[$];
    wr_t wr_q[$];
    int  bf_q[$];

    fft_stage_ctrl_if #(.N_LOG2(3))  if3 ();
    fft_stage_ctrl_if #(.N_LOG2(10)) if10 ();

    fft_stage_ctrl #(.N_LOG2(3)) u_dut3 (
        .clk   (clk),
        .reset (reset),
        .bus   (if3)
    );

    fft_stage_ctrl #(.N_LOG2(10)) u_dut10 (
        .clk   (clk),
        .reset (reset),
        .bus   (if10)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic test_reset();
        reset = 1'b1;
        if3.i_start = 1'b0;
        if10.i_start = 1'b0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        n_cmp++;
        if (if3.o_busy !== 1'b0 || if3.o_done !== 1'b0 || if3.o_rd_en !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_ctl: busy/done/rd got %b%b%b want 000", if3.o_busy, if3.o_done, if3.o_rd_en);
        end
        n_cmp++;
        if (if3.o_bf_start !== 1'b0 || if3.o_wr_en !== 1'b0 || int'(if3.o_stage) !== 0) begin
            n_bad++;
            $display("FAIL reset_pipe: bf/wr %b%b stage %0d want 00 0", if3.o_bf_start, if3.o_wr_en, if3.o_stage);
        end
        n_cmp++;
        if (int'(if3.o_rd_addr_a) !== 0 || int'(if3.o_wr_addr_b) !== 0 || int'(if3.o_tw_addr) !== 0) begin
            n_bad++;
            $display("FAIL reset_addr: rda %0d wrb %0d tw %0d want 0", if3.o_rd_addr_a, if3.o_wr_addr_b, if3.o_tw_addr);
        end
        n_cmp++;
        if (if10.o_busy !== 1'b0 || if10.o_wr_en !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_big: busy %b wr %b want 0 0", if10.o_busy, if10.o_wr_en);
        end
    endtask

    task automatic load_model();
        rd_q.delete();
        wr_q.delete();
        bf_q.delete();
        for (int s = 0; s < 3; s++) begin
            int half;
            int ngrp;
            half = 1 << s;
            ngrp = 8 / (2 * half);
            for (int g = 0; g < ngrp; g++) begin
                for (int j = 0; j < half; j++) begin
                    rd_t e;
                    e.a  = g * 2 * half + j;
                    e.b  = e.a + half;
                    e.tw = j * ngrp;
                    e.s  = s;
                    rd_q.push_back(e);
                end
            end
        end
    endtask

    task automatic test_run(input string tag);
        load_model();
        @(posedge clk);
        #1 if3.i_start = 1'b1;
        @(posedge clk);
        #1 if3.i_start = 1'b0;
        for (int c = 1; c <= 27; c++) begin
            bit exp_rd;
            bit exp_bf;
            bit exp_wr;
            int exp_s;
            @(negedge clk);
            exp_rd = (c <= 24) && (((c - 1) % 8) < 4);
            exp_s  = (c <= 24) ? (c - 1) / 8 : 2;
            n_cmp++;
            if (if3.o_rd_en !== exp_rd) begin
                n_bad++;
                $display("FAIL %s rd_en c%0d: got %b want %b", tag, c, if3.o_rd_en, exp_rd);
            end
            n_cmp++;
            if (if3.o_busy !== (c <= 25) || if3.o_done !== (c == 25)) begin
                n_bad++;
                $display("FAIL %s busy/done c%0d: got %b%b want %b%b", tag, c, if3.o_busy, if3.o_done, c <= 25, c == 25);
            end
            if (c <= 25) begin
                n_cmp++;
                if (int'(if3.o_stage) !== exp_s) begin
                    n_bad++;
                    $display("FAIL %s stage c%0d: got %0d want %0d", tag, c, if3.o_stage, exp_s);
                end
            end
            if (exp_rd && rd_q.size() > 0) begin
                rd_t e;
                wr_t w;
                e = rd_q.pop_front();
                n_cmp++;
                if (int'(if3.o_rd_addr_a) !== e.a || int'(if3.o_rd_addr_b) !== e.b || int'(if3.o_tw_addr) !== e.tw) begin
                    n_bad++;
                    $display("FAIL %s rd_addr c%0d: got (%0d,%0d)t%0d want (%0d,%0d)t%0d", tag, c, if3.o_rd_addr_a, if3.o_rd_addr_b, if3.o_tw_addr, e.a, e.b, e.tw);
                end
                w.a = e.a;
                w.b = e.b;
                w.due = c + 4;
                wr_q.push_back(w);
                bf_q.push_back(c + 1);
            end
            exp_bf = (bf_q.size() > 0) && (bf_q[0] == c);
            if (exp_bf) void'(bf_q.pop_front());
            n_cmp++;
            if (if3.o_bf_start !== exp_bf) begin
                n_bad++;
                $display("FAIL %s bf_start c%0d: got %b want %b", tag, c, if3.o_bf_start, exp_bf);
            end
            exp_wr = (wr_q.size() > 0) && (wr_q[0].due == c);
            n_cmp++;
            if (if3.o_wr_en !== exp_wr) begin
                n_bad++;
                $display("FAIL %s wr_en c%0d: got %b want %b", tag, c, if3.o_wr_en, exp_wr);
            end
            if (exp_wr) begin
                wr_t w;
                w = wr_q.pop_front();
                n_cmp++;
                if (int'(if3.o_wr_addr_a) !== w.a || int'(if3.o_wr_addr_b) !== w.b) begin
                    n_bad++;
                    $display("FAIL %s wr_addr c%0d: got (%0d,%0d) want (%0d,%0d)", tag, c, if3.o_wr_addr_a, if3.o_wr_addr_b, w.a, w.b);
                end
            end
        end
        n_cmp++;
        if (rd_q.size() != 0 || wr_q.size() != 0 || bf_q.size() != 0) begin
            n_bad++;
            $display("FAIL %s leftover: rd %0d wr %0d bf %0d want 0", tag, rd_q.size(), wr_q.size(), bf_q.size());
        end
    endtask

    task automatic test_held_start();
        @(posedge clk);
        #1 if3.i_start = 1'b1;
        @(posedge clk);
        #1;
        for (int c = 1; c <= 30; c++) begin
            bit exp_busy;
            @(negedge clk);
            exp_busy = (c <= 25) || (c >= 27);
            n_cmp++;
            if (if3.o_busy !== exp_busy) begin
                n_bad++;
                $display("FAIL held busy c%0d: got %b want %b", c, if3.o_busy, exp_busy);
            end
            if (c == 27) begin
                n_cmp++;
                if (if3.o_rd_en !== 1'b1 || int'(if3.o_rd_addr_a) !== 0 || int'(if3.o_rd_addr_b) !== 1) begin
                    n_bad++;
                    $display("FAIL held rerun: rd %b (%0d,%0d) want 1 (0,1)", if3.o_rd_en, if3.o_rd_addr_a, if3.o_rd_addr_b);
                end
            end
        end
        @(posedge clk);
        #1 if3.i_start = 1'b0;
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic test_reset_midrun();
        @(posedge clk);
        #1 if3.i_start = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (c == 1) if3.i_start = 1'b0;
        end
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        for (int c = 11; c <= 16; c++) begin
            @(negedge clk);
            n_cmp++;
            if (if3.o_busy !== 1'b0 || if3.o_rd_en !== 1'b0 || if3.o_bf_start !== 1'b0 || if3.o_wr_en !== 1'b0 || if3.o_done !== 1'b0) begin
                n_bad++;
                $display("FAIL abort c%0d: busy rd bf wr done %b%b%b%b%b want 00000", c, if3.o_busy, if3.o_rd_en, if3.o_bf_start, if3.o_wr_en, if3.o_done);
            end
        end
        test_run("post_reset");
    endtask

    task automatic test_big_run();
        int done_c;
        int rd_cnt;
        int wr_cnt;
        int busy_cnt;
        done_c = 0;
        rd_cnt = 0;
        wr_cnt = 0;
        busy_cnt = 0;
        @(posedge clk);
        #1 if10.i_start = 1'b1;
        @(posedge clk);
        #1 if10.i_start = 1'b0;
        for (int c = 1; c <= 6000; c++) begin
            @(negedge clk);
            if (if10.o_busy === 1'b1) busy_cnt++;
            if (if10.o_wr_en === 1'b1) wr_cnt++;
            if (if10.o_rd_en === 1'b1) begin
                int diff;
                rd_cnt++;
                diff = int'(if10.o_rd_addr_b) - int'(if10.o_rd_addr_a);
                n_cmp++;
                if (diff !== (1 << if10.o_stage)) begin
                    n_bad++;
                    $display("FAIL big_pair c%0d: diff %0d want %0d", c, diff, 1 << if10.o_stage);
                end
            end
            if (if10.o_done === 1'b1) begin
                done_c = c;
                break;
            end
        end
        n_cmp++;
        if (done_c !== 5161) begin
            n_bad++;
            $display("FAIL big_done: cycle %0d want 5161", done_c);
        end
        n_cmp++;
        if (wr_cnt !== 5120 || rd_cnt !== 5120) begin
            n_bad++;
            $display("FAIL big_count: wr %0d rd %0d want 5120 5120", wr_cnt, rd_cnt);
        end
        n_cmp++;
        if (busy_cnt !== 5161) begin
            n_bad++;
            $display("FAIL big_busy: %0d want 5161", busy_cnt);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_bad = 0;
        test_reset();
        test_run("run1");
        test_held_start();
        test_reset_midrun();
        test_big_run();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/fft_stage_ctrl.md
Name: fft_stage_ctrl

Overview:
In-place radix-2 DIT FFT sequencer. It drives the dual-port sample RAM read/write addresses, the twiddle ROM address and the butterfly start strobe. It walks all log2(N) stages and issues one butterfly per clock. Between stages it drains the read+butterfly pipeline so no read overtakes a pending write-back. The datapath (RAM, twiddle ROM, 3-stage butterfly) is external; this block carries no sample data. Input samples are already in bit-reversed order in RAM.

Parameters:
N_LOG2, 10, log2 of FFT length N (N=1024); legal range 2..12
RD_LAT, 1, sample RAM and twiddle ROM read latency in cycles
BF_LATENCY, 3, butterfly i_start-to-o_valid latency in cycles
STAGE_W, $clog2(N_LOG2), width of stage index

Ports:
clk  in  1  clock
reset  in  1  synchronous, active-high reset
i_start  in  1  one-cycle request to run a full FFT; accepted only in IDLE
o_busy  out  1  high from the cycle after acceptance through the DONE cycle
o_done  out  1  one-cycle pulse when the last write-back has committed
o_stage  out  STAGE_W  current stage index, 0..N_LOG2-1
o_rd_en  out  1  RAM read enable for both ports
o_rd_addr_a  out  N_LOG2  RAM port A read address
o_rd_addr_b  out  N_LOG2  RAM port B read address
o_tw_addr  out  N_LOG2-1  twiddle ROM address, issued with o_rd_en
o_bf_start  out  1  butterfly i_start; o_rd_en delayed RD_LAT cycles
o_wr_en  out  1  RAM write enable; o_rd_en delayed RD_LAT+BF_LATENCY cycles
o_wr_addr_a  out  N_LOG2  write address for butterfly output A (read addr A, delayed)
o_wr_addr_b  out  N_LOG2  write address for butterfly output B (read addr B, delayed)

Behaviour:
- Reset: state=IDLE; all outputs 0; delay lines cleared. Reset mid-run aborts immediately. o_wr_en is 0 from the next cycle; no write-back completes after reset.
- States: IDLE -> RUN on i_start. RUN -> DRAIN after issuing butterfly k=N/2-1. DRAIN -> RUN (stage+1) after D=RD_LAT+BF_LATENCY cycles if stage<N_LOG2-1, else DRAIN -> DONE. DONE -> IDLE after 1 cycle.
- i_start outside IDLE is ignored (no queuing). i_start in DONE is also ignored.
- RUN: o_rd_en=1 every cycle. Counter k runs 0..N/2-1. Stage s uses half=1<<s, group=k>>s, pos=k&(half-1).
- Address generation: addr_a=(group<<(s+1))|pos; addr_b=addr_a+half; tw_addr=pos<<(N_LOG2-1-s).
- Outputs o_rd_addr_*, o_tw_addr and o_rd_en are registered and valid in the same cycle.
- DRAIN and DONE: o_rd_en=0. The delay lines keep shifting, so o_bf_start and o_wr_en still emit their tail.
- Delay lines: o_bf_start = o_rd_en delayed RD_LAT cycles. o_wr_en and o_wr_addr_a/b = o_rd_en and read addresses delayed RD_LAT+BF_LATENCY cycles. Shift-register implementation, reset to 0.
- Hazard rule: the last write of stage s is in the cycle immediately before the first read of stage s+1. Zero overlap, zero extra bubble.
- Timing: run accepted at edge E; RUN starts in cycle 1. Stage cycles = N/2+D. o_done is in cycle N_LOG2*(N/2+D)+1, which is also the last o_busy cycle.
- o_stage updates on the RUN entry of each stage and holds through DRAIN. Reset value 0.

Decomposition:
- Shared package fft_pkg: N_LOG2, RD_LAT, BF_LATENCY defaults and the state encoding (IDLE, RUN, DRAIN, DONE).
- One natural sub-module: fft_addr_gen, combinational (s,k) -> (addr_a, addr_b, tw_addr), reusable by an IFFT controller.
- Delay lines stay inline.

Test Plan:
- N_LOG2=3, pulse i_start -> stage 0 reads (0,1),(2,3),(4,5),(6,7), tw_addr 0,0,0,0 in cycles 1-4; o_rd_en=0 in cycles 5-8.
- Same run, stage 1 -> reads (0,2)t0, (1,3)t2, (4,6)t0, (5,7)t2. Stage 2 -> (0,4)t0, (1,5)t1, (2,6)t2, (3,7)t3.
- Same run -> o_bf_start in cycles 2-5. o_wr_en in cycles 5-8 with o_wr_addr (0,1)..(6,7). Stage 1 first read in cycle 9. o_done=1 only in cycle 25; o_busy high in cycles 1-25.
- i_start held high in cycles 0-30 -> exactly one run accepted at cycle 0. Second run starts in the cycle after IDLE is re-entered (cycle 27).
- reset asserted in cycle 10 of a run -> from cycle 11: o_busy, o_rd_en, o_bf_start, o_wr_en, o_done all 0. A new i_start runs normally from stage 0.
- N_LOG2=10 full run -> exactly 5120 o_wr_en cycles, 10*(512+4)=5160 run cycles, every address pair satisfies addr_b-addr_a=1<<stage.
